// File: rtl/jk_register_bank.sv
// ---------------------------------------------------------------------------
// jk_register_bank
//   WIDTH-channel bank of JK flip-flops advanced by an internal clock-enable
//   tick (one tick every DIV clk cycles). Three run modes: independent JK,
//   synchronous binary up-counter and serial shift register, plus hold.
//   Each channel has an active-low preset/clear pair that acts on every clk
//   edge regardless of tick/en and overrides the tick update for that bit.
//
// Parameters
//   WIDTH   number of channels (>=1)
//   DIV     clk cycles per tick (>=1)
//
// Ports
//   clk     system clock, all state on posedge
//   rst     asynchronous active-low reset
//   en      divider run enable (0 freezes the divider, no ticks)
//   mode    00 JK, 01 counter, 10 shift, 11 hold
//   j, k    per-channel JK inputs (mode 00)
//   sd_n    per-channel preset, active-low
//   rd_n    per-channel clear, active-low
//   ser_in  serial input into channel 0 (mode 10)
//   q       channel state
//   q_n     complement state (high together with q only while sd_n=rd_n=0)
//   tick    registered one-cycle update strobe
//   carry   registered one-cycle counter wrap strobe
//
// Strobe semantics: tick and carry are single-cycle valid pulses with no
// ready/backpressure. The edge that samples tick==1 is the update edge; q
// and carry reflect that update in the following cycle.
// ---------------------------------------------------------------------------
module jk_register_bank #(
    parameter int WIDTH = 4,
    parameter int DIV   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] sd_n,
    input  logic [WIDTH-1:0] rd_n,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tick,
    output logic             carry
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;

    logic [CNT_W-1:0] div_cnt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] inv_r;
    logic             tick_r;
    logic             carry_r;

    logic [WIDTH-1:0] upd_q;
    logic             upd_carry;

    // Tick-driven next state, computed from the current q only. Preset/clear
    // is applied afterwards per bit, so a forced bit still feeds its
    // neighbours with its old value in counter and shift modes.
    always_comb begin
        upd_q     = q_r;
        upd_carry = 1'b0;
        if (tick_r) begin
            case (mode)
                MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({j[i], k[i]})
                            2'b01:   upd_q[i] = 1'b0;
                            2'b10:   upd_q[i] = 1'b1;
                            2'b11:   upd_q[i] = ~q_r[i];
                            default: upd_q[i] = q_r[i];
                        endcase
                    end
                end
                MODE_COUNT: begin
                    upd_q     = q_r + WIDTH'(1);
                    upd_carry = &q_r;
                end
                MODE_SHIFT: begin
                    upd_q[0] = ser_in;
                    for (int i = 1; i < WIDTH; i++) begin
                        upd_q[i] = q_r[i-1];
                    end
                end
                default: upd_q = q_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tick_r  <= 1'b0;
            carry_r <= 1'b0;
            q_r     <= '0;
            inv_r   <= '0;
        end else begin
            // Divider: tick is raised on the edge where the count wraps.
            if (en) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    tick_r  <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + CNT_W'(1);
                    tick_r  <= 1'b0;
                end
            end else begin
                tick_r <= 1'b0;
            end

            carry_r <= upd_carry;

            for (int i = 0; i < WIDTH; i++) begin
                if (!sd_n[i]) begin
                    q_r[i] <= 1'b1;
                end else if (!rd_n[i]) begin
                    q_r[i] <= 1'b0;
                end else begin
                    q_r[i] <= upd_q[i];
                end
                // Both-low marks the bit so q_n is forced high alongside q.
                inv_r[i] <= ~sd_n[i] & ~rd_n[i];
            end
        end
    end

    assign q     = q_r;
    assign q_n   = ~q_r | inv_r;
    assign tick  = tick_r;
    assign carry = carry_r;

endmodule

// File: tb/tb_jk_register_bank.sv
// ---------------------------------------------------------------------------
// tb_jk_register_bank
//   Directed bench for jk_register_bank with WIDTH=4, DIV=4. Tick-driven
//   updates are checked by a monitor that pops {carry, q_n, q} expectations
//   from a queue on the cycle after each tick; divider timing, reset and
//   preset/clear behaviour are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_jk_register_bank;

    localparam int W   = 4;
    localparam int DIV = 4;
    localparam int EW  = 2 * W + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, sd_n, rd_n;
    logic         ser_in;
    logic [W-1:0] q, q_n;
    logic         tick, carry;

    jk_register_bank #(.WIDTH(W), .DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .j      (j),
        .k      (k),
        .sd_n   (sd_n),
        .rd_n   (rd_n),
        .ser_in (ser_in),
        .q      (q),
        .q_n    (q_n),
        .tick   (tick),
        .carry  (carry)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: q/carry show a tick update the cycle after tick was high
    logic prev_tick = 1'b0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (prev_tick && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("update{carry,q_n,q}", 32'({carry, q_n, q}), 32'(e));
        end
        prev_tick = rst ? tick : 1'b0;
    end

    // driver tasks
    task automatic next_tick();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (tick) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: no tick within 20 cycles");
        end
    endtask

    task automatic force_q(input logic [W-1:0] sd, input logic [W-1:0] rd);
        sd_n = sd;
        rd_n = rd;
        @(posedge clk);
        #1;
        sd_n = '1;
        rd_n = '1;
    endtask

    task automatic apply(input logic [1:0] m, input logic [W-1:0] jj, input logic [W-1:0] kk,
                         input logic s, input logic [EW-1:0] e);
        next_tick();
        mode   = m;
        j      = jj;
        k      = kk;
        ser_in = s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mode = 2'b11;
    endtask

    int cyc;
    int nt;

    initial begin
        rst = 1'b0; en = 1'b1; mode = 2'b11;
        j = '0; k = '0; sd_n = '1; rd_n = '1; ser_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: reset while tick is high and q nonzero
        force_q(4'b0000, 4'b1111);
        check("preset_all", 32'(q), 32'hF);
        next_tick();
        #2 rst = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_q_n", 32'(q_n), 32'hF);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_carry", 32'(carry), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 20 && cyc == 0; c++) begin
            @(posedge clk);
            #1;
            if (tick) cyc = c;
        end
        check("first_tick_latency", 32'(cyc), 32'd4);

        // 2: tick period, freeze with en=0, phase resumes
        nt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (tick) nt++;
        end
        check("ticks_in_12", 32'(nt), 32'd3);
        check("tick_on_12th", 32'(tick), 32'h1);
        en = 1'b0;
        nt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (tick) nt++;
        end
        check("ticks_while_frozen", 32'(nt), 32'd0);
        en  = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 20 && cyc == 0; c++) begin
            @(posedge clk);
            #1;
            if (tick) cyc = c;
        end
        check("resume_latency", 32'(cyc), 32'd4);

        // 3: JK mode, q=0110, j=0011, k=0101 -> q=0011
        force_q(4'b1001, 4'b0110);
        check("setup_0110", 32'(q), 32'h6);
        apply(2'b00, 4'b0011, 4'b0101, 1'b0, {1'b0, 4'b1100, 4'b0011});

        // 4: counter 16 ticks from 0000, carry on wrap only
        force_q(4'b1111, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] qv;
            qv = W'(i + 1);
            apply(2'b01, 4'b1111, 4'b1111, 1'b0, {(i == 15), ~qv, qv});
        end

        // 5: shift ser_in 1,0,1,1 from 0000
        force_q(4'b1111, 4'b0000);
        apply(2'b10, '0, '0, 1'b1, {1'b0, 4'b1110, 4'b0001});
        apply(2'b10, '0, '0, 1'b0, {1'b0, 4'b1101, 4'b0010});
        apply(2'b10, '0, '0, 1'b1, {1'b0, 4'b1010, 4'b0101});
        apply(2'b10, '0, '0, 1'b1, {1'b0, 4'b0100, 4'b1011});

        // preset on a tick edge in counter mode: 0011+1=0100, bit3 forced -> 1100
        force_q(4'b1100, 4'b0011);
        next_tick();
        mode = 2'b01;
        sd_n = 4'b0111;
        exp_q.push_back({1'b0, 4'b0011, 4'b1100});
        @(posedge clk);
        #1;
        sd_n = '1;
        mode = 2'b11;

        // 6: off-tick clear of bit 2, then both-low on bit 1
        force_q(4'b0000, 4'b1111);
        next_tick();
        @(posedge clk);
        #1;
        rd_n = 4'b1011;
        @(posedge clk);
        #1;
        check("clr2_q", 32'(q), 32'hB);
        check("clr2_q_n", 32'(q_n), 32'h4);
        sd_n = 4'b1101;
        rd_n = 4'b1101;
        @(posedge clk);
        #1;
        check("both_low_q", 32'(q), 32'hB);
        check("both_low_q_n", 32'(q_n), 32'h6);
        sd_n = '1;
        rd_n = '1;
        @(posedge clk);
        #1;
        check("release_q", 32'(q), 32'hB);
        check("release_q_n", 32'(q_n), 32'h4);

        // drain scoreboard
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
